// File: rtl/vga_timing_rx.sv
// vga_timing_rx: recovers pixel coordinates from a raster stream (sync/blank edges only),
// checks line/frame geometry, locks after clean frames and emits coordinate-tagged pixels.
module vga_timing_rx #(
    parameter int   H_ACTIVE    = 800,
    parameter int   V_ACTIVE    = 600,
    parameter int   H_TOTAL     = 1056,
    parameter int   V_TOTAL     = 628,
    parameter logic HS_ACT      = 1'b1,
    parameter logic VS_ACT      = 1'b1,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic        px_valid,
    output logic [9:0]  px_row,
    output logic [9:0]  px_col,
    output logic [7:0]  px_red,
    output logic [7:0]  px_green,
    output logic [7:0]  px_blue,
    output logic        sof,
    output logic        locked,
    output logic        err_h,
    output logic        err_v,
    output logic [10:0] meas_h_total,
    output logic [9:0]  meas_v_total
);
    typedef enum logic [1:0] {SEARCH, SYNCING, LOCKED} state_t;
    state_t state, state_nx;
    logic s1_hs, s1_vs, s1_blank, s2_hs, s2_vs, s2_blank, px_act;
    logic [7:0] s1_red, s1_green, s1_blue;
    logic [10:0] clk_cnt;
    logic [9:0] act_px, row_cnt, act_ln, ln_cnt, row_b, act_ln_b, ln_b;
    logic [2:0] good, good_nx;
    logic h_en, v_en, dirty, hs_e, vs_e, act_start, line_end, h_bad, v_bad, clean, enter_search;

    assign hs_e      = s1_hs == HS_ACT && s2_hs != HS_ACT;
    assign vs_e      = s1_vs == VS_ACT && s2_vs != VS_ACT;
    assign act_start = !s1_blank && s2_blank;
    assign line_end  = hs_e && act_px != '0;
    // a coincident vs edge is applied first, so the hs edge lands in the new frame
    assign row_b     = vs_e ? '0 : row_cnt;
    assign act_ln_b  = vs_e ? '0 : act_ln;
    assign ln_b      = vs_e ? '0 : ln_cnt;
    assign h_bad     = hs_e && h_en && (clk_cnt != 11'(H_TOTAL) || (act_px != '0 && act_px != 10'(H_ACTIVE)));
    assign v_bad     = vs_e && v_en && (ln_cnt != 10'(V_TOTAL) || act_ln != 10'(V_ACTIVE));
    assign clean     = !dirty && !h_bad && !v_bad;
    assign good_nx   = clean ? good + 3'd1 : 3'd0;
    assign enter_search = state != SEARCH && state_nx == SEARCH;

    assign locked   = state == LOCKED;
    assign px_valid = locked && px_act;
    assign sof      = px_valid && px_row == '0 && px_col == '0;

    always_comb begin
        state_nx = state;
        state_nx = state == SEARCH  ? (vs_e ? SYNCING : SEARCH) :
                   state == SYNCING ? ((vs_e && clean && good_nx == 3'(LOCK_FRAMES)) ? LOCKED : SYNCING) :
                   ((err_h || err_v) ? SEARCH : LOCKED);
    end

    // sync history resets to the asserted level so a release mid-pulse creates no false edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_hs    <= HS_ACT;
            s2_hs    <= HS_ACT;
            s1_vs    <= VS_ACT;
            s2_vs    <= VS_ACT;
            s1_blank <= 1'b1;
            s2_blank <= 1'b1;
            s1_red   <= '0;
            s1_green <= '0;
            s1_blue  <= '0;
            px_act   <= 1'b0;
            px_row   <= '0;
            px_col   <= '0;
            px_red   <= '0;
            px_green <= '0;
            px_blue  <= '0;
        end else begin
            s1_hs    <= hs;
            s1_vs    <= vs;
            s1_blank <= blank;
            s1_red   <= red;
            s1_green <= green;
            s1_blue  <= blue;
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;
            s2_blank <= s1_blank;
            px_act   <= !s1_blank;
            px_row   <= row_cnt;
            px_red   <= s1_red;
            px_green <= s1_green;
            px_blue  <= s1_blue;
            if (!s1_blank)
                px_col <= act_start ? '0 : px_col + {9'd0, px_col != 10'(H_ACTIVE - 1)};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= SEARCH;
            clk_cnt      <= '0;
            act_px       <= '0;
            row_cnt      <= '0;
            act_ln       <= '0;
            ln_cnt       <= '0;
            meas_h_total <= '0;
            meas_v_total <= '0;
            err_h        <= 1'b0;
            err_v        <= 1'b0;
            dirty        <= 1'b0;
            good         <= '0;
            h_en         <= 1'b0;
            v_en         <= 1'b0;
        end else begin
            state   <= state_nx;
            clk_cnt <= hs_e ? 11'd1 : clk_cnt + {10'd0, !(&clk_cnt)};
            act_px  <= hs_e ? {9'd0, !s1_blank} : act_px + {9'd0, !s1_blank && !(&act_px)};
            row_cnt <= row_b + {9'd0, line_end && row_b != 10'(V_ACTIVE - 1)};
            act_ln  <= act_ln_b + {9'd0, line_end && !(&act_ln_b)};
            ln_cnt  <= ln_b + {9'd0, hs_e && !(&ln_b)};
            if (hs_e)
                meas_h_total <= clk_cnt;
            if (vs_e)
                meas_v_total <= ln_cnt;
            err_h <= h_bad;
            err_v <= v_bad;
            dirty <= !vs_e && (dirty || h_bad || v_bad);
            if (vs_e)
                good <= state == SEARCH ? 3'd0 : good_nx;
            h_en <= !enter_search && (h_en || hs_e);
            v_en <= !enter_search && (v_en || vs_e);
        end
    end
endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: scoreboard bench on a reduced raster geometry; expected pixels are queued
// with their due cycle as the raster is driven and compared when the DUT should present them.
module tb_vga_timing_rx;
    localparam int HA = 16, VA = 6, HT = 28, VT = 10;
    localparam int HSW = 4, HBP = 4, VSW = 2, VBP = 1;
    localparam int HS0 = HSW + HBP, VS0 = VSW + VBP;

    typedef struct packed {
        int         due;
        logic [9:0] row;
        logic [9:0] col;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       sof;
    } item_t;

    logic clock = 1'b0, reset_n = 1'b0, hs = 1'b0, vs = 1'b0, blank = 1'b1;
    logic [7:0] red = '0, green = '0, blue = '0;
    logic px_valid, sof, locked, err_h, err_v;
    logic [9:0] px_row, px_col, meas_v_total;
    logic [7:0] px_red, px_green, px_blue;
    logic [10:0] meas_h_total;

    int errors = 0, checks = 0, cyc = 0, nvalid = 0, nerr_h = 0, nerr_v = 0;
    logic [10:0] last_meas_h = '0;
    logic [9:0] last_meas_v = '0;
    logic prev_err = 1'b0;
    item_t q[$];

    vga_timing_rx #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
                    .HS_ACT(1'b1), .VS_ACT(1'b1), .LOCK_FRAMES(2)) dut (
        .clock(clock), .reset_n(reset_n), .hs(hs), .vs(vs), .blank(blank),
        .red(red), .green(green), .blue(blue),
        .px_valid(px_valid), .px_row(px_row), .px_col(px_col),
        .px_red(px_red), .px_green(px_green), .px_blue(px_blue),
        .sof(sof), .locked(locked), .err_h(err_h), .err_v(err_v),
        .meas_h_total(meas_h_total), .meas_v_total(meas_v_total)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        item_t it;
        logic due;
        due = q.size() != 0 && q[0].due == cyc;
        it = due ? q.pop_front() : '0;
        check("px_valid", px_valid, due);
        check("sof", sof, due && it.sof);
        if (due)
            check("pixel", {px_row, px_col, px_red, px_green, px_blue},
                  {it.row, it.col, it.r, it.g, it.b});
        if (px_valid)
            nvalid++;
        if (err_h) begin
            nerr_h++;
            last_meas_h = meas_h_total;
        end
        if (err_v) begin
            nerr_v++;
            last_meas_v = meas_v_total;
        end
        if (prev_err)
            check("unlock", {locked, px_valid}, 2'b00);
        prev_err = err_h | err_v;
    end

    // one raster frame: sync, back porch, active, front porch on both axes
    task automatic drive_frame(input int short_line, input int wide_line, input bit extra_row,
                               input int lock_to, input int rst_line, output int npx);
        int start, v0;
        item_t it;
        start = nvalid;
        v0 = extra_row ? VS0 - 1 : VS0;
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < (v == short_line ? HT - 1 : HT); h++) begin
                int row, col;
                logic act;
                @(negedge clock);
                if (v == rst_line && h == 0) begin
                    reset_n = 1'b0;
                    #1;
                    check("rst_out", {px_valid, sof, locked, err_h, err_v, px_row, px_col,
                                      |px_red, |px_green, |px_blue, meas_h_total, meas_v_total}, '0);
                end
                if (v == rst_line && h == 2)
                    reset_n = 1'b1;
                row = v - v0;
                col = h - HS0;
                act = v >= v0 && v < VS0 + VA && col >= 0 && col < (v == wide_line ? HA + 1 : HA);
                hs = h < HSW;
                vs = v < VSW;
                blank = !act;
                red = 8'(col);
                green = 8'(row);
                blue = 8'($urandom_range(0, 255));
                if (act && v < lock_to) begin
                    it.due = cyc + 2;
                    it.row = 10'(row > VA - 1 ? VA - 1 : row);
                    it.col = 10'(col > HA - 1 ? HA - 1 : col);
                    it.r = red;
                    it.g = green;
                    it.b = blue;
                    it.sof = row == 0 && col == 0;
                    q.push_back(it);
                end
            end
        end
        npx = nvalid - start;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        check("rst_state", {px_valid, sof, locked, err_h, err_v, px_row, px_col,
                            |px_red, |px_green, |px_blue, meas_h_total, meas_v_total}, '0);
        reset_n = 1'b1;
        // clean raster: lock at start of frame 3
        drive_frame(-1, -1, 1'b0, 0, -1, n);
        drive_frame(-1, -1, 1'b0, 0, -1, n);
        check("f2_px", n, 0);
        drive_frame(-1, -1, 1'b0, VT, -1, n);
        check("f3_px", n, HA * VA);
        drive_frame(-1, -1, 1'b0, VT, -1, n);
        check("a_meas", {meas_h_total, meas_v_total}, {11'(HT), 10'(VT)});
        check("a_errs", {16'(nerr_h), 16'(nerr_v)}, '0);
        check("a_lock", locked, 1'b1);
        // one short line
        drive_frame(5, -1, 1'b0, 6, -1, n);
        check("b_px", n, 3 * HA);
        check("b_err_h", nerr_h, 1);
        check("b_meas_h", last_meas_h, HT - 1);
        drive_frame(-1, -1, 1'b0, 0, -1, n);
        drive_frame(-1, -1, 1'b0, 0, -1, n);
        check("b_f7_px", n, 0);
        drive_frame(-1, -1, 1'b0, VT, -1, n);
        check("b_relock_px", n, HA * VA);
        // one line with an extra active pixel
        drive_frame(-1, 5, 1'b0, 6, -1, n);
        check("c_px", n, 3 * HA + 1);
        check("c_err_h", nerr_h, 2);
        check("c_meas_h", last_meas_h, HT);
        drive_frame(-1, -1, 1'b0, 0, -1, n);
        drive_frame(-1, -1, 1'b0, 0, -1, n);
        drive_frame(-1, -1, 1'b0, VT, -1, n);
        check("c_relock_px", n, HA * VA);
        // reset in the middle of a locked frame
        drive_frame(-1, -1, 1'b0, 5, 5, n);
        check("d_px", n, 2 * HA);
        drive_frame(-1, -1, 1'b0, 0, -1, n);
        drive_frame(-1, -1, 1'b0, 0, -1, n);
        drive_frame(-1, -1, 1'b0, VT, -1, n);
        check("d_relock_px", n, HA * VA);
        check("d_errs", {16'(nerr_h), 16'(nerr_v)}, {16'd2, 16'd0});
        // one extra active line with total kept
        drive_frame(-1, -1, 1'b1, VT, -1, n);
        check("e_px", n, (VA + 1) * HA);
        drive_frame(-1, -1, 1'b0, 0, -1, n);
        check("e_err_v", nerr_v, 1);
        check("e_err_h", nerr_h, 2);
        check("e_meas_v", last_meas_v, VT);
        check("e_lock", locked, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_rx.md
# vga_timing_rx

Receive-side counterpart of the `vga` timing generator. It consumes a raster stream (hs/vs/blank plus 8-bit RGB) in the 40 MHz pixel domain and recovers pixel coordinates from the sync and blank edges alone. It measures line and frame geometry against 800x600@60 parameters, declares lock after consecutive clean frames, and emits coordinate-tagged pixels. It sits between the draw/mix logic and the `hdmi_tx_0` input as an in-system checker, and it is the front end for any frame-capture path.

## Interface
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 600, active lines per frame
- H_TOTAL, 1056, clocks per line (hs assert edge to hs assert edge)
- V_TOTAL, 628, lines per frame (hs assert edges between vs assert edges)
- HS_ACT, 1'b1, asserted level of hs
- VS_ACT, 1'b1, asserted level of vs
- LOCK_FRAMES, 2, consecutive error-free frames required to lock (1..7)
- clock  in  1  pixel clock, 40 MHz
- reset_n  in  1  asynchronous, active-low reset
- hs, vs, blank  in  1 each  raster timing; blank=1 outside the active area
- red, green, blue  in  8 each  pixel colour
- px_valid  out  1  active pixel on px_*, only while locked
- px_row  out  10  recovered row, 0..V_ACTIVE-1
- px_col  out  10  recovered column, 0..H_ACTIVE-1
- px_red, px_green, px_blue  out  8 each  delayed colour
- sof  out  1  one-cycle pulse with the first pixel (row 0, col 0) of a frame while locked
- locked  out  1  geometry lock
- err_h, err_v  out  1 each  one-cycle line/frame error pulses
- meas_h_total  out  11  last measured line length, saturates at 2047
- meas_v_total  out  10  last measured frame length in lines, saturates at 1023

## Operation
- Stage 1 registers all inputs. Stage 2 detects edges on the registered signals: hs assert, vs assert, and active start (blank 1->0).
- col_cnt clears on active start, increments per active clock, and saturates at H_ACTIVE-1. act_px counts active clocks per line and saturates at 1023.
- row_cnt clears on vs assert edge and increments at each hs assert edge that ends a line with act_px>0. act_ln counts active lines per frame.
- clk_cnt counts clocks between hs assert edges. ln_cnt counts hs assert edges between vs assert edges.
- Line check at each hs assert edge, skipped for the first edge after reset or after entering SEARCH:
  - Error if clk_cnt != H_TOTAL.
  - Error if act_px is nonzero and != H_ACTIVE.
  - On error, pulse err_h.
  - On every edge, load meas_h_total and clear the counters.
- Frame check at each vs assert edge, skipped for the first edge:
  - Error if ln_cnt != V_TOTAL or act_ln != V_ACTIVE.
  - On error, pulse err_v.
  - Load meas_v_total.
- When hs and vs assert edges coincide, the vs edge is processed first; that hs edge counts as line 1 of the new frame.
- FSM states are SEARCH, SYNCING, LOCKED. Reset state is SEARCH.
  - SEARCH -> SYNCING on vs assert edge; good=0.
  - SYNCING: at each vs edge, increment good if no err_h/err_v since the previous vs edge, otherwise clear good. Go to LOCKED when good reaches LOCK_FRAMES.
  - LOCKED -> SEARCH on any err_h or err_v.
- locked=1 only in LOCKED. px_valid = LOCKED and registered ~blank.

## Timing
- Reset (async assert, synchronous-safe release) sets every output to 0, FSM to SEARCH, and all counters and check-enables to 0.
- Pixel latency is 2 clocks: a pixel at the input in cycle t appears on px_* in cycle t+2, together with its px_row/px_col.
- err_h/err_v pulse in cycle t+2 relative to the sampled offending sync edge. meas_* update in the same cycle.
- locked rises in the cycle of the vs-edge pulse that completes good=LOCK_FRAMES. The first px_valid is 1 clock later than the first active pixel of that frame's stage-2 data.
- locked and px_valid fall in the cycle after the error pulse. Pixels already in stage 2 are suppressed.
- Reset mid-frame: outputs drop immediately. The block ignores the partial frame and rearms on the next vs edge.

## Test plan
- Clean 800x600 raster for 4 frames after reset -> err_h=err_v=0; meas_h_total=1056, meas_v_total=628; locked rises at frame 3 start. Frame 3 gives exactly 480000 px_valid, first at (0,0) with sof, last at (599,799).
- Locked; shorten one line to 1055 clocks -> single err_h; locked=0 next cycle; meas_h_total=1055; relock exactly 2 clean frames later.
- Locked; extend one line's active region to 801 pixels -> err_h at the following hs edge; px_col holds 799 for the extra pixel, then the block unlocks.
- Frame with 601 active lines (V_TOTAL kept) -> err_v at next vs edge, meas_v_total=628, locked=0.
- Input colour ramp red=col[7:0], green=row[7:0] -> every px_valid cycle shows px_red=px_col[7:0] and px_green=px_row[7:0], confirming 2-cycle alignment.
- Assert reset_n=0 at row 300 -> all outputs 0 within the same cycle; after release, no err pulse on the first hs/vs edges; relock after LOCK_FRAMES clean frames.
